debug_step_gen: RTL and testbench
=================================

# debug_step_gen

Generates the `debug_en` / `debug_step` pair consumed by the CPU controller's debug suspend/step logic. Each rising edge of `debug_step` releases exactly one CPU clock cycle.
- **Inputs:** debounced board buttons for single-step and resume, a debug-mode switch, a PC breakpoint comparator, and a host-issued "run N cycles" command.
- **Placement:** sits between board I/O / host and the controller's `DEBUG` inputs.
- **Counter:** keeps a count of stepped cycles for the display.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required before a button level change is accepted (use 1_000_000 on board).
- `CNT_W`, default 32: width of `step_cnt`.
- `clk`  in  1  main clock.
- `rst`  in  1  reset; synchronous, active-high.
- `sw_debug`  in  1  debug-mode switch (level).
- `btn_step`  in  1  raw single-step button (asynchronous, bouncy).
- `btn_run`  in  1  raw resume button (asynchronous, bouncy).
- `cmd_run`  in  1  one-cycle pulse: execute `run_n` steps.
- `run_n`  in  16  step count for `cmd_run`, sampled with it.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  32  breakpoint PC.
- `pc`  in  32  current CPU PC.
- `debug_en`  out  1  CPU suspend request (combinational).
- `debug_step`  out  1  step clock; registered.
- `busy`  out  1  step sequence in progress.
- `bp_hit`  out  1  sticky: halted by breakpoint.
- `step_cnt`  out  CNT_W  number of steps issued since reset.

## Operation
- **Button path (`btn_step`, `btn_run` independently):**
  - 2-FF synchroniser, then stability counter.
  - Debounced level changes after `DEBOUNCE_CYCLES` consecutive equal samples differing from the current level.
  - A 0→1 debounced transition yields a one-cycle `press` pulse.
- **Breakpoint match:** `bp_match = bp_en && pc == bp_addr && !bp_mask`.
- **FSM states:** FREE, HALT, STEP_HI, STEP_LO.
- **FREE:**
  - CPU free-runs.
  - Go to HALT if `sw_debug` or `bp_match`; on `bp_match` set `bp_hit`.
  - `bp_mask` clears when `pc != bp_addr`.
- **HALT:**
  - `cmd_run` with `run_n != 0`: latch `remaining = run_n`, go to STEP_HI.
  - Else `step_press`: `remaining = 1`, go to STEP_HI.
  - Else `run_press` with `sw_debug == 0`: go to FREE, set `bp_mask`, clear `bp_hit`.
  - `cmd_run` with `run_n == 0` is ignored. `run_press` while `sw_debug == 1` is ignored.
  - Priority: `cmd_run` > step press > run press; lower-priority events in the same cycle are dropped.
  - Any accepted step command clears `bp_hit`.
- **STEP_HI:**
  - `debug_step = 1`; the CPU executes one cycle.
  - `step_cnt++`, `remaining--`; go to STEP_LO.
- **STEP_LO:**
  - `debug_step = 0`.
  - If `bp_en && pc == bp_addr`: set `bp_hit`, clear `remaining`, go to HALT.
  - Else if `remaining != 0`: go to STEP_HI.
  - Else: go to HALT.
- **Outputs:**
  - `debug_en = (state != FREE) | sw_debug | bp_match`. It is combinational so a breakpoint suspends the CPU in the same cycle the PC matches.
  - `busy = (state == STEP_HI) | (state == STEP_LO)`.
- **Input handling while busy:** `cmd_run`, presses and `sw_debug` changes are ignored.
- **Counter:** `step_cnt` wraps modulo 2^CNT_W.

## Timing
- **Reset values:** state FREE, `debug_step` 0, `busy` 0, `bp_hit` 0, `step_cnt` 0, `bp_mask` 0, `remaining` 0, debounced levels 0, debounce counters 0. `debug_en` follows its equation (0 when `sw_debug = 0` and no match).
- **Reset mid-sequence:** abort on the same edge; `debug_step` low the next cycle; no further steps.
- **Command to first step:** a command accepted in HALT at cycle t gives STEP_HI (`debug_step = 1`) at t+1 and STEP_LO at t+2.
- **N-step sequence:**
  - Steps repeat with period 2 cycles.
  - The last STEP_LO falls at t+2N; HALT and `busy = 0` at t+2N+1.
  - `step_cnt` updates the cycle after each STEP_HI.
- **Button latency:** `press` arrives 2 + `DEBOUNCE_CYCLES` cycles after the raw edge stabilises. A held button gives a single press.
- **Entering HALT:** FREE to HALT takes 1 cycle after `sw_debug` rises. `debug_en` rises in the same cycle as `sw_debug`.
- **Breakpoint during multi-step:** checked in STEP_LO after the PC update. Remaining steps are cancelled.

## Test plan
- **Reset:** `rst` for 2 cycles with `sw_debug = 0` -> all outputs 0; CPU free-runs (`debug_en = 0`).
- **Single step:** `sw_debug = 1`, `btn_step` pulse with 3 bounces then held, `DEBOUNCE_CYCLES = 4` -> exactly one `debug_step` high cycle; `step_cnt = 1`; state returns to HALT.
- **Run N:** in HALT, `cmd_run` with `run_n = 5` -> 5 `debug_step` pulses, 2 cycles apart. `busy` is high for 10 cycles; `step_cnt` goes 0→5. A `btn_step` press mid-run is ignored.
- **Breakpoint in free run:** `bp_en = 1`, `bp_addr = 0x0000_0010`, `pc` counts by 4 -> `debug_en = 1` in the cycle `pc = 0x10`; `bp_hit = 1`.
- **Resume after breakpoint:** from the breakpoint HALT, `sw_debug = 0` and `btn_run` press -> FREE with `bp_hit` cleared; no re-halt while `pc` is still `0x10`; re-halts when `pc` returns to `0x10`.
- **Breakpoint stops a run:** `cmd_run` with `run_n = 8`, `pc` reaches `bp_addr` after step 3 -> HALT after 3 steps; `bp_hit = 1`, `step_cnt = 3`. Asserting `rst` in a second run's STEP_HI gives `debug_step = 0` next cycle and `step_cnt = 0`.

Source files
------------

// File: rtl/debug_step_gen.sv
// Debug suspend/step generator: debounced step/run buttons, host run-N command and a
// PC breakpoint drive the CPU controller's debug_en / debug_step pair.
module debug_step_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_debug,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             cmd_run,
  input  logic [15:0]      run_n,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             debug_en,
  output logic             debug_step,
  output logic             busy,
  output logic             bp_hit,
  output logic [CNT_W-1:0] step_cnt
);

  typedef enum logic [1:0] {FREE, HALT, STEP_HI, STEP_LO} state_t;

  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] btn_raw;
  logic [1:0] press;
  logic       step_press;
  logic       run_press;

  assign btn_raw    = {btn_run, btn_step};
  assign step_press = press[0];
  assign run_press  = press[1];

  // Per-button synchroniser, stability counter and rising-edge press pulse
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic            sync_a;
    logic            sync_b;
    logic            level;
    logic            prs;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_a <= 1'b0;
        sync_b <= 1'b0;
        level  <= 1'b0;
        prs    <= 1'b0;
        cnt    <= '0;
      end else begin
        sync_a <= btn_raw[i];
        sync_b <= sync_a;
        prs    <= 1'b0;
        if (sync_b != level) begin
          if (cnt == DB_LAST) begin
            level <= sync_b;
            prs   <= sync_b;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign press[i] = prs;
  end

  state_t           state, state_nxt;
  logic [15:0]      remaining, remaining_nxt;
  logic [CNT_W-1:0] step_cnt_nxt;
  logic             bp_hit_nxt;
  logic             bp_mask, bp_mask_nxt;
  logic             bp_eq;
  logic             bp_match;

  assign bp_eq    = (pc == bp_addr);
  assign bp_match = bp_en && bp_eq && !bp_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FREE;
      remaining  <= '0;
      step_cnt   <= '0;
      bp_hit     <= 1'b0;
      bp_mask    <= 1'b0;
      debug_step <= 1'b0;
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      step_cnt   <= step_cnt_nxt;
      bp_hit     <= bp_hit_nxt;
      bp_mask    <= bp_mask_nxt;
      debug_step <= (state_nxt == STEP_HI);
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    step_cnt_nxt  = step_cnt;
    bp_hit_nxt    = bp_hit;
    bp_mask_nxt   = bp_mask;
    unique case (state)
      FREE: begin
        if (!bp_eq) bp_mask_nxt = 1'b0;
        if (bp_match) begin
          bp_hit_nxt = 1'b1;
          state_nxt  = HALT;
        end else if (sw_debug) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        // Host command outranks the step button, which outranks resume
        if (cmd_run && run_n != 16'd0) begin
          remaining_nxt = run_n;
          bp_hit_nxt    = 1'b0;
          state_nxt     = STEP_HI;
        end else if (step_press) begin
          remaining_nxt = 16'd1;
          bp_hit_nxt    = 1'b0;
          state_nxt     = STEP_HI;
        end else if (run_press && !sw_debug) begin
          bp_mask_nxt = 1'b1;
          bp_hit_nxt  = 1'b0;
          state_nxt   = FREE;
        end
      end
      STEP_HI: begin
        step_cnt_nxt  = step_cnt + 1'b1;
        remaining_nxt = remaining - 16'd1;
        state_nxt     = STEP_LO;
      end
      STEP_LO: begin
        // PC has advanced past the stepped cycle; the mask does not apply here
        if (bp_en && bp_eq) begin
          bp_hit_nxt    = 1'b1;
          remaining_nxt = 16'd0;
          state_nxt     = HALT;
        end else if (remaining != 16'd0) begin
          state_nxt = STEP_HI;
        end else begin
          state_nxt = HALT;
        end
      end
      default: state_nxt = FREE;
    endcase
  end

  assign debug_en = (state != FREE) | sw_debug | bp_match;
  assign busy     = (state == STEP_HI) | (state == STEP_LO);

endmodule

// File: tb/tb_debug_step_gen.sv
// Directed bench for debug_step_gen: a per-cycle vector table plus hand sequences for
// debounced buttons, run-N, breakpoints, resume, reset mid-step and counter wrap.
module tb_debug_step_gen;

  localparam int DEB   = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             sw_debug;
  logic             btn_step;
  logic             btn_run;
  logic             cmd_run;
  logic [15:0]      run_n;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc;
  logic             debug_en;
  logic             debug_step;
  logic             busy;
  logic             bp_hit;
  logic [CNT_W-1:0] step_cnt;

  int n_vec = 0;
  int n_err = 0;

  debug_step_gen #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sw_debug(sw_debug), .btn_step(btn_step), .btn_run(btn_run),
    .cmd_run(cmd_run), .run_n(run_n), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .debug_en(debug_en), .debug_step(debug_step), .busy(busy), .bp_hit(bp_hit),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sw;
    logic        cmd;
    logic [15:0] n;
    logic        bpen;
    logic [31:0] pc;
    logic        en;
    logic        step;
    logic        busy;
    logic        hit;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic r, input logic s, input logic c, input logic [15:0] n,
                              input logic b, input logic [31:0] p, input logic e,
                              input logic st, input logic bz, input logic h, input logic [3:0] k);
    vec_t v;
    v.rst = r; v.sw = s; v.cmd = c; v.n = n; v.bpen = b; v.pc = p;
    v.en = e; v.step = st; v.busy = bz; v.hit = h; v.cnt = k;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic sw);
    rst = 1'b1; sw_debug = sw; cmd_run = 1'b0; run_n = '0;
    btn_step = 1'b0; btn_run = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  int steps;
  int busy_cyc;
  int first_step;
  int last_step;
  int cyc;

  initial begin
    rst = 1'b1; sw_debug = 1'b0; btn_step = 1'b0; btn_run = 1'b0; cmd_run = 1'b0;
    run_n = '0; bp_en = 1'b0; bp_addr = 32'h10; pc = '0;

    //          rst sw cmd n   bpen pc     en st bz hit cnt
    tbl[0]  = mk(1, 0, 0, 0,  0, 32'h00, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0,  0, 32'h00, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0,  0, 32'h04, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0,  0, 32'h04, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 0,  0, 32'h04, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 2,  0, 32'h04, 1, 1, 1, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0,  0, 32'h04, 1, 0, 1, 0, 1);
    tbl[7]  = mk(0, 1, 0, 0,  0, 32'h04, 1, 1, 1, 0, 1);
    tbl[8]  = mk(0, 1, 0, 0,  0, 32'h04, 1, 0, 1, 0, 2);
    tbl[9]  = mk(0, 1, 0, 0,  0, 32'h04, 1, 0, 0, 0, 2);
    tbl[10] = mk(0, 0, 0, 0,  0, 32'h04, 1, 0, 0, 0, 2);
    tbl[11] = mk(1, 0, 0, 0,  0, 32'h04, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0,  1, 32'h08, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0,  1, 32'h0C, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,  1, 32'h10, 1, 0, 0, 1, 0);
    tbl[15] = mk(0, 0, 0, 0,  1, 32'h14, 1, 0, 0, 1, 0);
    tbl[16] = mk(0, 0, 1, 1,  1, 32'h14, 1, 1, 1, 0, 0);
    tbl[17] = mk(0, 0, 0, 0,  1, 32'h10, 1, 0, 1, 0, 1);
    tbl[18] = mk(0, 0, 0, 0,  1, 32'h10, 1, 0, 0, 1, 1);

    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst; sw_debug = tbl[i].sw; cmd_run = tbl[i].cmd; run_n = tbl[i].n;
      bp_en = tbl[i].bpen; pc = tbl[i].pc;
      tick();
      check($sformatf("vec%0d en/step/busy/hit/cnt", i),
            {debug_en, debug_step, busy, bp_hit, step_cnt},
            {tbl[i].en, tbl[i].step, tbl[i].busy, tbl[i].hit, tbl[i].cnt});
    end
    cmd_run = 1'b0; bp_en = 1'b0;

    // Bouncy step button: exactly one step
    do_reset(1'b1);
    steps = 0;
    for (int i = 0; i < 6; i++) begin
      btn_step = ~btn_step;
      tick();
      if (debug_step) steps++;
    end
    btn_step = 1'b1;
    for (int i = 0; i < 30; i++) begin tick(); if (debug_step) steps++; end
    for (int i = 0; i < 6; i++) begin
      btn_step = ~btn_step;
      tick();
      if (debug_step) steps++;
    end
    btn_step = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (debug_step) steps++; end
    check("single_step pulses", steps, 1);
    check("single_step cnt", step_cnt, 1);
    check("single_step halt", {busy, debug_en}, 2'b01);

    // Run press while sw_debug is set is ignored
    btn_run = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    sw_debug = 1'b0;
    tick();
    check("run_press_sw1 ignored", debug_en, 1'b1);
    btn_run = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Run 5 with a step press arriving mid-run
    do_reset(1'b1);
    cmd_run = 1'b1; run_n = 16'd5;
    tick();
    cmd_run = 1'b0; run_n = '0;
    check("run5 first step latency", debug_step, 1'b1);
    btn_step = 1'b1;
    steps = 0; busy_cyc = 0; first_step = -1; last_step = -1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) tick();
      if (debug_step) begin
        steps++;
        if (first_step < 0) first_step = c;
        last_step = c;
      end
      if (busy) busy_cyc++;
    end
    check("run5 pulses", steps, 5);
    check("run5 spacing", last_step - first_step, 8);
    check("run5 busy cycles", busy_cyc, 10);
    check("run5 cnt", step_cnt, 5);
    btn_step = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Breakpoint in free run, resume, re-halt
    do_reset(1'b0);
    bp_en = 1'b1; bp_addr = 32'h10;
    pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pc = pc + 32'd4;
    end
    #1;
    check("bp comb debug_en", debug_en, 1'b1);
    tick();
    check("bp halt hit", {debug_en, bp_hit}, 2'b11);
    btn_run = 1'b1;
    cyc = 0;
    while (debug_en && cyc < 40) begin tick(); cyc++; end
    check("resume free", {debug_en, bp_hit}, 2'b00);
    for (int i = 0; i < 3; i++) tick();
    check("resume no rehalt at same pc", debug_en, 1'b0);
    pc = 32'h14;
    tick();
    check("free pc14", debug_en, 1'b0);
    pc = 32'h10;
    #1;
    check("rehalt comb", debug_en, 1'b1);
    tick();
    check("rehalt hit", bp_hit, 1'b1);
    btn_run = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Breakpoint cancels a run of 8 after step 3
    do_reset(1'b1);
    bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h4;
    cmd_run = 1'b1; run_n = 16'd8;
    tick();
    cmd_run = 1'b0; run_n = '0;
    steps = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) tick();
      if (debug_step) begin steps++; pc = pc + 32'd4; end
    end
    check("bp_run pulses", steps, 3);
    check("bp_run hit/busy", {bp_hit, busy}, 2'b10);
    check("bp_run cnt", step_cnt, 3);

    // Reset asserted during STEP_HI of a second run
    pc = 32'h40;
    cmd_run = 1'b1; run_n = 16'd4;
    tick();
    cmd_run = 1'b0; run_n = '0;
    check("run2 step_hi", debug_step, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid-step", {debug_step, busy, step_cnt}, {1'b0, 1'b0, 4'd0});
    steps = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (debug_step) steps++; end
    check("rst no further steps", steps, 0);

    // Counter wraps modulo 2^CNT_W
    do_reset(1'b1);
    bp_en = 1'b0;
    cmd_run = 1'b1; run_n = 16'd17;
    tick();
    cmd_run = 1'b0; run_n = '0;
    cyc = 0;
    while (busy && cyc < 60) begin tick(); cyc++; end
    check("wrap cnt", {busy, step_cnt}, {1'b0, 4'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
